// File: rtl/muldiv_hilo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Purpose  : Shared op codes, controller state encoding and default sizes
//             for the HI/LO divide controller.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

  localparam int WIDTH_DEF      = 32;
  localparam int WAIT_LIMIT_DEF = 48;

  localparam logic [1:0] OP_DIVU = 2'd0;
  localparam logic [1:0] OP_DIV  = 2'd1;
  localparam logic [1:0] OP_MTHI = 2'd2;
  localparam logic [1:0] OP_MTLO = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_FIX    = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_hilo_ctrl_if
//  Purpose  : Controller <-> divider core handshake bundle. The controller
//             is the master (issues start/operands), the core the slave.
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_hilo_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             div_start;
  logic [WIDTH-1:0] div_dividend;
  logic [WIDTH-1:0] div_divisor;
  logic             div_busy;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] div_r;

  modport master (
    output div_start, div_dividend, div_divisor,
    input  div_busy, div_q, div_r
  );

  modport slave (
    input  div_start, div_dividend, div_divisor,
    output div_busy, div_q, div_r
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl_sign_adj.sv
`default_nettype none
// ============================================================================
//  Module   : sign_adj
//  Purpose  : Conditional two's-complement negate, y = neg ? -x : x.
//             Wraps at WIDTH bits, so -MIN == MIN.
//  Revision : 1.0  initial release
// ============================================================================
module sign_adj #(
  parameter int WIDTH = 32
) (
  input  logic             neg,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y
);

  // Negate on request; used for operand magnitude and result sign fix-up.
  assign y = neg ? -x : x;

endmodule
`default_nettype wire

// File: rtl/muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_hilo_ctrl
//  Purpose  : EX-stage sequencer for DIV/DIVU/MTHI/MTLO. Owns HI/LO, drives
//             the external unsigned restoring divider, sign-corrects signed
//             results and stalls the pipeline while a divide is outstanding.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_hilo_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int WAIT_LIMIT = WAIT_LIMIT_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             mf_req,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_err,
  muldiv_hilo_ctrl_if.master core
);

  localparam int CW = $clog2(WAIT_LIMIT + 1);

  state_t           state;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] rs_hold;   // raw dividend, becomes HI on divide-by-zero
  logic [CW-1:0]    wait_cnt;

  logic             is_div;
  logic [WIDTH-1:0] rs_abs;
  logic [WIDTH-1:0] rt_abs;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  assign is_div = (op_code == OP_DIV);

  // Operand magnitudes: only a signed DIV folds negative operands.
  sign_adj #(.WIDTH(WIDTH)) u_abs_rs (
    .neg (is_div & rs_val[WIDTH-1]),
    .x   (rs_val),
    .y   (rs_abs)
  );

  sign_adj #(.WIDTH(WIDTH)) u_abs_rt (
    .neg (is_div & rt_val[WIDTH-1]),
    .x   (rt_val),
    .y   (rt_abs)
  );

  // Result correction: quotient negative when signs differ, remainder
  // follows the dividend sign.
  sign_adj #(.WIDTH(WIDTH)) u_fix_q (
    .neg (neg_q),
    .x   (core.div_q),
    .y   (q_fix)
  );

  sign_adj #(.WIDTH(WIDTH)) u_fix_r (
    .neg (neg_r),
    .x   (core.div_r),
    .y   (r_fix)
  );

  // Freeze the pipeline whenever a divide is in flight; MT*/MF* in idle are free.
  assign stall = (state != S_IDLE) | (mf_req & (state != S_IDLE));

  // Controller FSM with registered HI/LO, core handshake and error pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      state             <= S_IDLE;
      hi                <= '0;
      lo                <= '0;
      div_err           <= 1'b0;
      core.div_start    <= 1'b0;
      core.div_dividend <= '0;
      core.div_divisor  <= '0;
      neg_q             <= 1'b0;
      neg_r             <= 1'b0;
      dz                <= 1'b0;
      rs_hold           <= '0;
      wait_cnt          <= '0;
    end else begin
      div_err        <= 1'b0;
      core.div_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid) begin
            case (op_code)
              OP_MTHI: hi <= rs_val;
              OP_MTLO: lo <= rs_val;
              default: begin
                neg_q             <= is_div & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                neg_r             <= is_div & rs_val[WIDTH-1];
                core.div_dividend <= rs_abs;
                core.div_divisor  <= rt_abs;
                rs_hold           <= rs_val;
                if (rt_val == '0) begin
                  // Divide by zero never reaches the core.
                  dz    <= 1'b1;
                  state <= S_FIX;
                end else begin
                  // Start is registered so it is high during S_LAUNCH.
                  dz             <= 1'b0;
                  core.div_start <= 1'b1;
                  state          <= S_LAUNCH;
                end
              end
            endcase
          end
        end
        S_LAUNCH: begin
          wait_cnt <= '0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!core.div_busy) begin
            state <= S_FIX;
          end else if (wait_cnt == CW'(WAIT_LIMIT - 1)) begin
            // Core hung: abandon the divide, leave HI/LO untouched.
            div_err <= 1'b1;
            state   <= S_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_FIX: begin
          if (dz) begin
            lo <= '1;
            hi <= rs_hold;
          end else begin
            lo <= q_fix;
            hi <= r_fix;
          end
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_hilo_ctrl
//  Purpose  : Self-checking bench for muldiv_hilo_ctrl with a cycle-accurate
//             32-cycle divider core model and an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_muldiv_hilo_ctrl;
  import muldiv_pkg::*;

  logic        clock;
  logic        reset;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mf_req;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_err;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference architectural state.
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_hilo_ctrl_if #(.WIDTH(32)) bus ();

  muldiv_hilo_ctrl #(.WIDTH(32), .WAIT_LIMIT(48)) dut (
    .clock    (clock),
    .reset    (reset),
    .op_valid (op_valid),
    .op_code  (op_code),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .mf_req   (mf_req),
    .stall    (stall),
    .hi       (hi),
    .lo       (lo),
    .div_err  (div_err),
    .core     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Divider core model: busy for 32 cycles after the start edge.
  logic        force_busy;
  logic        c_busy;
  int          c_cnt;
  logic [31:0] c_dvd;
  logic [31:0] c_dvs;
  logic [31:0] c_q;
  logic [31:0] c_r;

  always @(posedge clock) begin
    if (reset) begin
      c_busy <= 1'b0;
      c_cnt  <= 0;
      c_q    <= '0;
      c_r    <= '0;
    end else if (bus.div_start) begin
      c_busy <= 1'b1;
      c_cnt  <= 32;
      c_dvd  <= bus.div_dividend;
      c_dvs  <= bus.div_divisor;
    end else if (c_busy) begin
      if (c_cnt == 1) begin
        c_busy <= 1'b0;
        c_q    <= (c_dvs != 0) ? c_dvd / c_dvs : 32'hFFFF_FFFF;
        c_r    <= (c_dvs != 0) ? c_dvd % c_dvs : c_dvd;
      end
      c_cnt <= c_cnt - 1;
    end
  end

  assign bus.div_busy = c_busy | force_busy;
  assign bus.div_q    = c_q;
  assign bus.div_r    = c_r;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural result {hi, lo} from plain signed/unsigned arithmetic.
  function automatic logic [63:0] ref_div(input logic [1:0] code, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (code == OP_DIV) begin
      sa = $signed(a);
      sb = $signed(b);
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] mag(input logic [1:0] code, input logic [31:0] a);
    longint sa;
    sa = $signed(a);
    if (code == OP_DIV && sa < 0) sa = -sa;
    else if (code != OP_DIV) return a;
    return sa[31:0];
  endfunction

  // Issue one divide at the current cycle (T) and follow it to completion.
  task automatic run_div(input string tag, input logic [1:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic mf);
    logic [63:0] sv, stv, ev, exp_res, exp_stall;
    logic [31:0] got_dvd, got_dvs;
    int          lat;
    lat       = (b == 0) ? 2 : 36;
    exp_res   = ref_div(code, a, b);
    exp_stall = ((64'd1 << lat) - 64'd1) & ~64'd1;
    sv = '0; stv = '0; ev = '0; got_dvd = '0; got_dvs = '0;
    op_valid = 1'b1; op_code = code; rs_val = a; rt_val = b; mf_req = mf;
    for (int c = 0; c <= lat; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      sv[c]  = stall;
      stv[c] = bus.div_start;
      ev[c]  = div_err;
      if (c == 1) begin
        got_dvd = bus.div_dividend;
        got_dvs = bus.div_divisor;
      end
      if (c == lat - 1) check({tag, " hilo_hold"}, {hi, lo}, {m_hi, m_lo});
      if (c >= 1 && !stall) begin
        op_valid = 1'b0;
        mf_req   = 1'b0;
      end
    end
    op_valid = 1'b0;
    mf_req   = 1'b0;
    m_hi = exp_res[63:32];
    m_lo = exp_res[31:0];
    check({tag, " hilo"}, {hi, lo}, exp_res);
    check({tag, " stall"}, sv, exp_stall);
    check({tag, " start"}, stv, (b == 0) ? 64'd0 : 64'd2);
    check({tag, " err"}, ev, 64'd0);
    if (b != 0) check({tag, " operands"}, {got_dvd, got_dvs}, {mag(code, a), mag(code, b)});
  endtask

  // MTHI/MTLO followed by an MF read the next cycle.
  task automatic run_mt(input string tag, input logic [1:0] code, input logic [31:0] v);
    op_valid = 1'b1; op_code = code; rs_val = v; rt_val = $urandom;
    #1;
    check({tag, " stall_T"}, {63'd0, stall}, 64'd0);
    @(posedge clock); #1;
    op_valid = 1'b0;
    mf_req   = 1'b1;
    if (code == OP_MTHI) m_hi = v; else m_lo = v;
    #1;
    check({tag, " stall_mf"}, {63'd0, stall}, 64'd0);
    check({tag, " hilo"}, {hi, lo}, {m_hi, m_lo});
    @(posedge clock); #1;
    mf_req = 1'b0;
  endtask

  initial begin : main
    logic [1:0]  code;
    logic [31:0] a, b;
    int          first_err, n_err;
    logic        stall_at_err;

    reset = 1'b1; op_valid = 1'b0; op_code = '0; rs_val = '0; rt_val = '0;
    mf_req = 1'b0; force_busy = 1'b0;
    m_hi = '0; m_lo = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset hilo", {hi, lo}, 64'd0);
    check("reset ctl", {61'd0, stall, bus.div_start, div_err}, 64'd0);
    check("reset operands", {bus.div_dividend, bus.div_divisor}, 64'd0);

    run_div("divu_100_7", OP_DIVU, 32'd100, 32'd7, 1'b0);
    check("divu_100_7 value", {hi, lo}, {32'd2, 32'd14});
    run_div("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2 value", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("div_7_m2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 1'b1);
    check("div_7_m2 value", {hi, lo}, {32'd1, 32'hFFFF_FFFD});
    run_div("div_min_m1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_min_m1 value", {hi, lo}, {32'd0, 32'h8000_0000});
    run_div("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b0);
    check("divu_5_0 value", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    run_div("div_m9_0", OP_DIV, 32'hFFFF_FFF7, 32'd0, 1'b1);

    run_mt("mthi", OP_MTHI, 32'h0000_1234);
    check("mthi value", {32'd0, hi}, {32'd0, 32'h0000_1234});
    run_mt("mtlo", OP_MTLO, $urandom);

    // Random divides, mixed signs, small and zero divisors.
    for (int i = 0; i < 12; i++) begin
      code = ($urandom_range(0, 1) == 0) ? OP_DIVU : OP_DIV;
      a    = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_div($sformatf("rand%0d", i), code, a, b, 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a divide.
    op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd1000; rt_val = 32'd3;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clock); #1;
    end
    reset = 1'b1; op_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    m_hi = '0; m_lo = '0;
    check("midreset hilo", {hi, lo}, 64'd0);
    check("midreset ctl", {62'd0, stall, bus.div_start}, 64'd0);
    check("midreset operands", {bus.div_dividend, bus.div_divisor}, 64'd0);
    @(posedge clock); #1;
    run_div("post_reset", OP_DIV, 32'hFFFF_FF9C, 32'd7, 1'b0);

    // Hung core: expect a single error pulse and no HI/LO update.
    force_busy = 1'b1;
    first_err = -1; n_err = 0; stall_at_err = 1'b1;
    op_valid = 1'b1; op_code = OP_DIVU; rs_val = 32'd77; rt_val = 32'd5;
    for (int c = 0; c <= 80; c++) begin
      if (c > 0) begin
        @(posedge clock); #1;
      end
      if (div_err) begin
        n_err++;
        if (first_err < 0) begin
          first_err    = c;
          stall_at_err = stall;
        end
      end
      if (c >= 1 && !stall) op_valid = 1'b0;
    end
    op_valid   = 1'b0;
    force_busy = 1'b0;
    check("timeout pulses", 64'(n_err), 64'd1);
    check("timeout window", {63'd0, (first_err >= 49 && first_err <= 51)}, 64'd1);
    check("timeout stall", {63'd0, stall_at_err}, 64'd0);
    check("timeout hilo", {hi, lo}, {m_hi, m_lo});
    repeat (3) @(posedge clock);
    #1;
    run_div("after_timeout", OP_DIVU, 32'hDEAD_BEEF, 32'd16, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
